// File: rtl/sram_sp_initiator.sv
// -----------------------------------------------------------------------------
// sram_sp_initiator
//
// Requester-side controller for a single-port synchronous SRAM macro with a
// one-cycle registered read and ME/WE strobes. Client requests arrive on a
// valid/ready channel and drive the SRAM pins combinationally. Read data
// returns through a small response FIFO that applies backpressure to the
// request side. After reset the whole array is zero-filled before requests
// are accepted. Sustains one request per cycle.
//
// Parameters
//   AW          SRAM address width (depth = 2**AW)
//   DW          SRAM data width
//   RESP_DEPTH  response FIFO entries (>=2 for full throughput)
//   CLEAR_EN    1: zero-fill the array after reset, 0: start directly in RUN
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active high
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid & req_ready
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data (ignored for reads)
//   rsp_valid  out  read data available
//   rsp_ready  in   client takes read data when rsp_valid & rsp_ready
//   rsp_rdata  out  read data, in request order
//   sram_me    out  SRAM memory enable
//   sram_we    out  SRAM write enable
//   sram_adr   out  SRAM address
//   sram_d     out  SRAM write data
//   sram_q     in   SRAM read data, valid the cycle after a read enable
//   init_done  out  high once the controller is in RUN
//   busy       out  clearing, a read in flight, or response FIFO non-empty
// -----------------------------------------------------------------------------
module sram_sp_initiator #(
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter int RESP_DEPTH = 2,
    parameter int CLEAR_EN   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_me,
    output logic          sram_we,
    output logic [AW-1:0] sram_adr,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q,
    output logic          init_done,
    output logic          busy
);

    // Pointer width for the FIFO, and a counter width with headroom for
    // occupancy plus one read still in flight.
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 2) + 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] clr_addr;
    logic [AW-1:0] clr_addr_next;

    logic          accept;
    logic          rd_pend;
    logic          push;
    logic          pop;
    logic [CW-1:0] occ;
    logic [CW-1:0] credit_used;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] fifo_mem [RESP_DEPTH];

    // The SRAM returns data one cycle after a read strobe, so the cycle
    // after an accepted read is the one that captures sram_q.
    assign push      = rd_pend;
    assign rsp_valid = (occ != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_rdata = fifo_mem[rd_ptr];

    // A read in flight already owns a FIFO slot; an entry leaving this
    // cycle frees one. occ + rd_pend >= pop always holds, so no underflow.
    assign credit_used = occ + CW'(rd_pend) - CW'(pop);

    assign init_done = (state == ST_RUN);
    assign busy      = (state == ST_CLEAR) | rd_pend | (occ != '0);

    // State register and clear address counter. Reset always restarts the
    // clear sweep from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // Next-state and SRAM pin drive. During CLEAR every cycle writes a zero
    // word; the cycle that writes the last address hands over to RUN. In
    // RUN the pins follow the request combinationally, but only when the
    // request is actually accepted, so a stalled request never touches the
    // macro.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        req_ready     = 1'b0;
        accept        = 1'b0;
        sram_me       = 1'b0;
        sram_we       = 1'b0;
        sram_adr      = '0;
        sram_d        = '0;

        case (state)
            ST_CLEAR: begin
                sram_me       = 1'b1;
                sram_we       = 1'b1;
                sram_adr      = clr_addr;
                clr_addr_next = clr_addr + AW'(1);
                if (clr_addr == '1) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = (credit_used < CW'(RESP_DEPTH));
                accept    = req_valid & req_ready;
                if (accept) begin
                    sram_me  = 1'b1;
                    sram_we  = req_we;
                    sram_adr = req_addr;
                    sram_d   = req_wdata;
                end
            end
        endcase
    end

    // Read tracking and the response FIFO. Push and pop may coincide, in
    // which case occupancy is unchanged. The credit rule guarantees a free
    // slot for every push, so there is no overflow guard here. Entries are
    // cleared on reset so rsp_rdata starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            rd_pend <= accept & ~req_we;

            if (push) begin
                fifo_mem[wr_ptr] <= sram_q;
                wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end

            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule
